// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: AES SubBytes over the 128-bit state, LANES bytes per clock.
// Each lane carries a forward and an inverse S-box. The latched per-block mode
// selects between them. The result is exposed only once the whole block is done.
module sub_bytes_seq #(
  parameter int LANES    = 4,
  parameter int OUT_HOLD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         inv_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int N     = 16 / LANES;
  localparam int CW    = 8 * LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam bit HOLD  = (OUT_HOLD != 0);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // Tables packed with entry 0 in the top byte. Entry b therefore sits at bit offset (255-b)*8 = {~b,3'b0}.
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return FWD_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return INV_TBL[idx +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       work_q, work_d;
  logic               mode_q, mode_d;
  logic [127:0]       hold_q, hold_d;

  logic [6:0]         pos;
  logic [CW-1:0]      chunk_in, chunk_out;
  logic [127:0]       work_merged;

  // Chunk datapath: pick chunk cnt (chunk 0 = top bytes) and run it through the lane S-boxes.
  always_comb begin
    pos         = 7'(CW * (N - 1 - int'(cnt_q)));
    chunk_in    = work_q[pos +: CW];
    chunk_out   = '0;
    for (int l = 0; l < LANES; l++) begin
      chunk_out[CW-1-8*l -: 8] = mode_q ? inv_sbox(chunk_in[CW-1-8*l -: 8])
                                        : fwd_sbox(chunk_in[CW-1-8*l -: 8]);
    end
    work_merged            = work_q;
    work_merged[pos +: CW] = chunk_out;
  end

  // Next-state logic: accept in IDLE, one chunk per cycle in BUSY, wait for out_ready in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          work_d  = data_in;
          mode_d  = inv_in;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        work_d = work_merged;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          hold_d  = work_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      mode_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  // The working register is visible only in DONE, so partial results never leak.
  assign data_out  = (state_q == DONE) ? work_q : (HOLD ? hold_q : 128'd0);

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq. It drives four instances: LANES 4/1/16 with held output, and LANES 2 with cleared output.
// Reference S-boxes are derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] data_in = '0;
  logic         inv_in = 1'b0;
  logic         in_valid  [4];
  logic         out_ready [4];
  logic         in_ready  [4];
  logic         out_valid [4];
  logic         busy      [4];
  logic [127:0] data_out  [4];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [127:0] sb[$];
  logic [7:0]   fwd_t [256];
  logic [7:0]   inv_t [256];

  localparam logic [127:0] V0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1 = 128'h638293c31bfc33f5c4eeacea4bc12816;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sub_bytes_seq #(
      .LANES   (g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 16 : 2),
      .OUT_HOLD(g == 3 ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .data_in  (data_in),
      .inv_in   (inv_in),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .data_out (data_out[g]),
      .busy     (busy[g])
    );
  end

  function automatic int nch(input int u);
    return (u == 0) ? 4 : (u == 1) ? 16 : (u == 2) ? 1 : 8;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] a2, b2, p;
    a2 = a; b2 = b; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b2[0]) p = p ^ a2;
      a2 = a2[7] ? ((a2 << 1) ^ 8'h1b) : (a2 << 1);
      b2 = b2 >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] xi, iv, s;
    for (int x = 0; x < 256; x++) begin
      xi = 8'(x);
      iv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(xi, 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      fwd_t[x] = s;
      inv_t[s] = xi;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < 16; b++)
      r[127-8*b -: 8] = inv ? inv_t[d[127-8*b -: 8]] : fwd_t[d[127-8*b -: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block for a single accept edge and record its expected result.
  task automatic send(input int u, input logic [127:0] d, input logic inv);
    data_in     = d;
    inv_in      = inv;
    in_valid[u] = 1'b1;
    sb.push_back(model(d, inv));
    tick();
    in_valid[u] = 1'b0;
  endtask

  // Cycles after the accept edge until out_valid, or -1 if it never comes.
  task automatic wait_out(input int u, output int lat);
    lat = -1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (out_valid[u]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int u = 0; u < 4; u++) begin
      tests_run++;
      if (in_ready[u] !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready[%0d] got %b want 1", u, in_ready[u]); end
      tests_run++;
      if (out_valid[u] !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid[%0d] got %b want 0", u, out_valid[u]); end
      tests_run++;
      if (busy[u] !== 1'b0) begin tests_failed++; $display("FAIL reset_busy[%0d] got %b want 0", u, busy[u]); end
      tests_run++;
      if (data_out[u] !== 128'd0) begin tests_failed++; $display("FAIL reset_data_out[%0d] got %h want 0", u, data_out[u]); end
    end
  endtask

  task automatic test_vectors();
    int lat;
    logic [127:0] d, exp_v, lit;
    for (int u = 0; u < 3; u++) begin
      for (int p = 0; p < 2; p++) begin
        d   = (p == 0) ? V0 : V1;
        lit = (p == 0) ? V1 : V0;
        send(u, d, p[0]);
        data_in = ~d;          // must have no effect while busy
        inv_in  = ~inv_in;
        wait_out(u, lat);
        tests_run++;
        if (lat !== nch(u)) begin tests_failed++; $display("FAIL vec_latency[%0d,%0d] got cycle %0d want cycle %0d", u, p, lat + 1, nch(u) + 1); end
        exp_v = sb.pop_front();
        tests_run++;
        if (data_out[u] !== exp_v) begin tests_failed++; $display("FAIL vec_data[%0d,%0d] got %h want %h", u, p, data_out[u], exp_v); end
        tests_run++;
        if (data_out[u] !== lit) begin tests_failed++; $display("FAIL vec_known[%0d,%0d] got %h want %h", u, p, data_out[u], lit); end
        out_ready[u] = 1'b1;
        tick();
        out_ready[u] = 1'b0;
        tests_run++;
        if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0) begin
          tests_failed++; $display("FAIL vec_release[%0d,%0d] got in_ready=%b out_valid=%b want 1/0", u, p, in_ready[u], out_valid[u]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] exp_v;
    send(0, V0, 1'b0);
    wait_out(0, lat);
    exp_v = sb.pop_front();
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (data_out[0] !== exp_v || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d] got data=%h ov=%b ir=%b want data=%h ov=1 ir=0", c, data_out[0], out_valid[0], in_ready[0], exp_v);
      end
      in_valid[0] = (c == 3);
      data_in     = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    tests_run++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      tests_failed++; $display("FAIL bp_release got ir=%b ov=%b busy=%b want 1/0/0", in_ready[0], out_valid[0], busy[0]);
    end
    tests_run++;
    if (data_out[0] !== exp_v) begin tests_failed++; $display("FAIL bp_hold_idle got %h want %h", data_out[0], exp_v); end
  endtask

  task automatic test_patterns();
    int lat;
    logic [127:0] exp_v;
    send(0, 128'd0, 1'b0);
    wait_out(0, lat);
    exp_v = sb.pop_front();
    tests_run++;
    if (data_out[0] !== exp_v || data_out[0] !== {16{8'h63}}) begin
      tests_failed++; $display("FAIL pat_zero got %h want %h", data_out[0], exp_v);
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    tests_run++;
    if (data_out[0] !== {16{8'h63}}) begin tests_failed++; $display("FAIL pat_hold_idle got %h want all 63", data_out[0]); end
    send(0, {128{1'b1}}, 1'b0);
    tests_run++;
    if (busy[0] !== 1'b1 || data_out[0] !== {16{8'h63}}) begin
      tests_failed++; $display("FAIL pat_hold_busy got busy=%b data=%h want 1 / all 63", busy[0], data_out[0]);
    end
    wait_out(0, lat);
    exp_v = sb.pop_front();
    tests_run++;
    if (data_out[0] !== exp_v || data_out[0] !== {16{8'h16}}) begin
      tests_failed++; $display("FAIL pat_ones got %h want %h", data_out[0], exp_v);
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk [3];
    logic [127:0] exp_v;
    int acc, outs, last;
    logic took;
    for (int i = 0; i < 3; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
    acc = 0; outs = 0; last = 0;
    out_ready[0] = 1'b1;
    data_in      = blk[0];
    inv_in       = 1'b0;
    in_valid[0]  = 1'b1;
    for (int c = 0; c < 60 && outs < 3; c++) begin
      if (out_valid[0]) begin
        exp_v = sb.pop_front();
        tests_run++;
        if (data_out[0] !== exp_v) begin tests_failed++; $display("FAIL b2b_data[%0d] got %h want %h", outs, data_out[0], exp_v); end
        outs++;
      end
      took = in_ready[0] && in_valid[0];
      if (took) begin
        if (acc > 0) begin
          tests_run++;
          if (c - last !== 6) begin tests_failed++; $display("FAIL b2b_spacing[%0d] got %0d want 6", acc, c - last); end
        end
        last = c;
        sb.push_back(model(data_in, inv_in));
        acc++;
      end
      tick();
      if (took) begin
        if (acc < 3) begin
          data_in = blk[acc];
          inv_in  = acc[0];
        end else begin
          in_valid[0] = 1'b0;
        end
      end
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    tests_run++;
    if (acc !== 3 || outs !== 3) begin tests_failed++; $display("FAIL b2b_count got acc=%0d outs=%0d want 3/3", acc, outs); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    logic [127:0] exp_v;
    send(3, V0, 1'b0);
    tick();                  // second BUSY cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_v = sb.pop_front();  // dropped block
    tests_run++;
    if (in_ready[3] !== 1'b1 || out_valid[3] !== 1'b0 || busy[3] !== 1'b0 || data_out[3] !== 128'd0) begin
      tests_failed++;
      $display("FAIL rmid_state got ir=%b ov=%b busy=%b data=%h want 1/0/0/0", in_ready[3], out_valid[3], busy[3], data_out[3]);
    end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid[3]) seen = 1'b1;
      tick();
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL rmid_no_valid got out_valid pulse want none"); end
    send(3, V1, 1'b1);
    tests_run++;
    if (busy[3] !== 1'b1 || data_out[3] !== 128'd0) begin
      tests_failed++; $display("FAIL rmid_busy_clear got busy=%b data=%h want 1/0", busy[3], data_out[3]);
    end
    wait_out(3, lat);
    tests_run++;
    if (lat !== 8) begin tests_failed++; $display("FAIL rmid_latency got cycle %0d want cycle 9", lat + 1); end
    exp_v = sb.pop_front();
    tests_run++;
    if (data_out[3] !== exp_v) begin tests_failed++; $display("FAIL rmid_data got %h want %h", data_out[3], exp_v); end
    out_ready[3] = 1'b1;
    tick();
    out_ready[3] = 1'b0;
    tests_run++;
    if (data_out[3] !== 128'd0 || in_ready[3] !== 1'b1) begin
      tests_failed++; $display("FAIL rmid_clear_idle got data=%h ir=%b want 0/1", data_out[3], in_ready[3]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int u = 0; u < 4; u++) begin
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b0;
    end
    build_tables();
    test_reset();
    test_vectors();
    test_backpressure();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
Sequential, parametrised SubBytes engine for the 128-bit AES state. It substitutes LANES bytes per clock, trading area for latency, and supports a per-block forward or inverse mode for encrypt and decrypt rounds. It sits between round-key addition and ShiftRows in the round datapath. It uses valid/ready handshakes on both sides so the round controller can stall it.

Parameters:
LANES, 4, number of S-box lanes (forward + inverse pair per lane); legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
OUT_HOLD, 1, 1 = data_out holds the last result after the output handshake; 0 = data_out is cleared to 0 after the output handshake.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  data_in/inv_in valid.
in_ready  output  1  engine can accept a block.
data_in  input  128  state to substitute; byte 0 = data_in[127:120], byte 15 = data_in[7:0].
inv_in  input  1  0 = forward S-box, 1 = inverse S-box; sampled with data_in.
out_valid  output  1  data_out holds a complete result.
out_ready  input  1  downstream accepts data_out.
data_out  output  128  substituted state, same byte order as data_in.
busy  output  1  high while state = BUSY.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- N = 16/LANES chunks per block. Chunk k covers bytes k*LANES .. k*LANES+LANES-1, processed MSB-first.
- States:
  - IDLE: in_ready=1.
  - BUSY: counter cnt runs 0..N-1.
  - DONE: out_valid=1.
- Transitions:
  - IDLE -> BUSY on in_valid && in_ready. At that edge data_in goes into the working register, inv_in goes into the mode register, and cnt is set to 0.
  - BUSY: each edge replaces chunk cnt of the working register with its S-box outputs (forward or inverse per the latched mode), then increments cnt. At cnt = N-1 the chunk is written and the state goes to DONE.
  - DONE -> IDLE on out_ready.
- Latency: an accept in cycle 0 gives BUSY in cycles 1..N and out_valid first high in cycle N+1. Examples: LANES=16 gives out_valid in cycle 2; LANES=1 gives cycle 17.
- Throughput: at most one block per N+2 cycles. in_ready is high only in IDLE; there is no accept in DONE, even with out_ready high.
- Handshake rules:
  - in_valid is ignored outside IDLE. data_in/inv_in changes during BUSY/DONE have no effect.
  - out_valid stays high and data_out stays stable until out_ready is seen. out_ready while out_valid=0 is ignored.
- data_out:
  - It is driven from the working register only in DONE.
  - In IDLE it shows the previous result if OUT_HOLD=1, or 0 if OUT_HOLD=0.
  - In BUSY it shows the previous result (OUT_HOLD=1) or 0 (OUT_HOLD=0). Partial results never reach data_out.
- Reset values: state=IDLE, cnt=0, working register=0, mode=0, in_ready=1 (first cycle after reset), out_valid=0, busy=0, data_out=0.
- Reset mid-operation (BUSY or DONE): the block is dropped with no out_valid pulse, all registers take reset values, and the engine is in IDLE next cycle.
- The mode is fixed per block. A mode change only takes effect on the next accept.
- S-box functions follow FIPS-197 exactly (forward S(0x00)=0x63, inverse InvS(0x63)=0x00). The lane S-boxes are purely combinational; only the chunk write is registered.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- LANES=4, forward, data_in=0x00112233445566778899aabbccddeeff -> out_valid in cycle 5, data_out=0x638293c31bfc33f5c4eeacea4bc12816.
- Same result, inv_in=1 with data_in=0x638293c31bfc33f5c4eeacea4bc12816 -> data_out=0x00112233445566778899aabbccddeeff. Repeat for LANES=1 (cycle 17) and LANES=16 (cycle 2).
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> data_out stable, in_ready=0 throughout; a new in_valid pulse is ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- All-zero state forward -> all bytes 0x63. All-0xFF forward -> all 0x16. Back-to-back blocks with out_ready tied high -> accepts spaced exactly N+2 cycles apart.
- Assert rst in BUSY cycle 2 of a LANES=2 block -> out_valid never rises, data_out=0, in_ready=1 the cycle after reset. The next block completes correctly.
- OUT_HOLD=0: after the output handshake, data_out=0 in IDLE. OUT_HOLD=1: data_out retains 0x6363...63 until the next DONE.
